// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, funct
// codes, ALU operation codes and FSM state codes.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_ADDIEX = 4'd9,
    ST_ADDIWB = 4'd10,
    ST_JUMP   = 4'd11,
    ST_HALT   = 4'd12
  } state_t;

  // States that wait on the memory handshake and feed the timeout counter.
  function automatic logic is_mem_state(input state_t st);
    return (st == ST_FETCH) || (st == ST_MEMRD) || (st == ST_MEMWR);
  endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// R-type funct field to ALU operation decode; flags unsupported funct codes.
module mips_alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       legal
);

  // Pure lookup; unknown funct yields a harmless AND code and legal=0.
  always_comb begin
    alu_control = ALU_AND;
    legal       = 1'b1;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_SLT:  alu_control = ALU_SLT;
      default: legal       = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM with retired-instruction counter, memory
// wait timeout and a sticky trap for illegal instructions or timeouts.
module mips_mc_control
  import mips_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic [1:0]       pc_source,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             reg_dest,
  output logic             memtoreg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_control,
  output logic [CNT_W-1:0] retired,
  output logic             trap,
  output logic [3:0]       state_o
);

  localparam int              WAIT_W    = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q;
  logic [CNT_W-1:0]   retired_q;
  logic               trap_q;
  logic               retire;
  logic               timeout;
  logic [2:0]         exec_alu;
  logic               funct_legal;

  mips_alu_decoder u_alu_dec (
    .funct       (funct),
    .alu_control (exec_alu),
    .legal       (funct_legal)
  );

  // This cycle is the WAIT_MAX-th consecutive stall of a memory access.
  assign timeout = is_mem_state(state_q) && !mem_ready && (wait_q == WAIT_LAST);

  // Next-state and control outputs; Moore except pc_en/ir_write gating.
  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    pc_en       = 1'b0;
    pc_source   = 2'b00;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    reg_dest    = 1'b0;
    memtoreg    = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = 3'b000;
    case (state_q)
      ST_FETCH: begin
        mem_read    = 1'b1;
        alu_src_b   = 2'b01;
        alu_control = ALU_ADD;
        if (timeout) begin
          state_d = ST_HALT;
        end else if (mem_ready) begin
          // Gated by reset so nothing is written while reset is held.
          ir_write = reset;
          pc_en    = reset;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        alu_src_b   = 2'b11;
        alu_control = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_EXEC;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_ADDI:      state_d = ST_ADDIEX;
          OP_J:         state_d = ST_JUMP;
          default:      state_d = ST_HALT;
        endcase
      end
      ST_MEMADR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
        state_d     = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      end
      ST_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (timeout)        state_d = ST_HALT;
        else if (mem_ready) state_d = ST_MEMWB;
      end
      ST_MEMWB: begin
        reg_write = 1'b1;
        memtoreg  = 1'b1;
        retire    = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (timeout) begin
          state_d = ST_HALT;
        end else if (mem_ready) begin
          retire  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_EXEC: begin
        alu_src_a = 1'b1;
        if (funct_legal) begin
          alu_control = exec_alu;
          state_d     = ST_ALUWB;
        end else begin
          state_d     = ST_HALT;
        end
      end
      ST_ALUWB: begin
        reg_write = 1'b1;
        reg_dest  = 1'b1;
        retire    = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_source   = 2'b01;
        pc_en       = zero;
        retire      = 1'b1;
        state_d     = ST_FETCH;
      end
      ST_ADDIEX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
        state_d     = ST_ADDIWB;
      end
      ST_ADDIWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_JUMP: begin
        pc_source = 2'b10;
        pc_en     = 1'b1;
        retire    = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  // State, stall counter, retired counter and sticky trap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_FETCH;
      wait_q    <= '0;
      retired_q <= '0;
      trap_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (is_mem_state(state_q) && !mem_ready && !timeout)
        wait_q <= wait_q + WAIT_W'(1);
      else
        wait_q <= '0;
      if (retire)
        retired_q <= retired_q + CNT_W'(1);
      if (state_d == ST_HALT)
        trap_q <= 1'b1;
    end
  end

  assign retired = retired_q;
  assign trap    = trap_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Scoreboard bench for mips_mc_control: stimulus pushes per-cycle expected
// snapshots, a negedge monitor pops and compares them against the DUT.
module tb_mips_mc_control;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pc_en, iord, mem_read, mem_write, ir_write;
  logic       reg_write, reg_dest, memtoreg, alu_src_a, trap;
  logic [1:0] pc_source, alu_src_b;
  logic [2:0] alu_control;
  logic [7:0] retired;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  mips_mc_control #(.CNT_W(8), .WAIT_MAX(15)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .pc_source(pc_source), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dest(reg_dest), .memtoreg(memtoreg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .retired(retired), .trap(trap), .state_o(state_o)
  );

  typedef struct packed {
    logic [1:0] pc_source;
    logic       iord, mem_read, mem_write, reg_write, reg_dest, memtoreg, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
  } moore_t;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_en;
    logic       ir_write;
    moore_t     m;
    logic       trap;
    logic [7:0] retired;
  } snap_t;

  typedef struct {
    snap_t v;
    string tag;
  } item_t;

  item_t      sb[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_ret;
  logic       exp_trap;
  logic [2:0] exec_aluc;

  // Hand-tabulated Moore outputs:
  // pc_source iord mem_read mem_write reg_write reg_dest memtoreg alu_src_a alu_src_b alu_control
  function automatic moore_t moore(input logic [3:0] st, input logic [2:0] ex);
    case (st)
      ST_FETCH:  return moore_t'(14'b00_0_1_0_0_0_0_0_01_010);
      ST_DECODE: return moore_t'(14'b00_0_0_0_0_0_0_0_11_010);
      ST_MEMADR: return moore_t'(14'b00_0_0_0_0_0_0_1_10_010);
      ST_MEMRD:  return moore_t'(14'b00_1_1_0_0_0_0_0_00_000);
      ST_MEMWB:  return moore_t'(14'b00_0_0_0_1_0_1_0_00_000);
      ST_MEMWR:  return moore_t'(14'b00_1_0_1_0_0_0_0_00_000);
      ST_EXEC:   return moore_t'({11'b00_0_0_0_0_0_0_1_00, ex});
      ST_ALUWB:  return moore_t'(14'b00_0_0_0_1_1_0_0_00_000);
      ST_BRANCH: return moore_t'(14'b01_0_0_0_0_0_0_1_00_110);
      ST_ADDIEX: return moore_t'(14'b00_0_0_0_0_0_0_1_10_010);
      ST_ADDIWB: return moore_t'(14'b00_0_0_0_1_0_0_0_00_000);
      ST_JUMP:   return moore_t'(14'b10_0_0_0_0_0_0_0_00_000);
      default:   return moore_t'(14'b0);
    endcase
  endfunction

  // Push the expected snapshot for the current cycle, then advance one cycle.
  task automatic step(input logic [3:0] st, input logic pcen, input logic irw, input string tag);
    item_t it;
    it.v   = {st, pcen, irw, moore(st, exec_aluc), exp_trap, exp_ret};
    it.tag = tag;
    sb.push_back(it);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    mem_ready = 1'b1;
    exp_ret   = 8'd0;
    exp_trap  = 1'b0;
    step(ST_FETCH, 1'b0, 1'b0, "reset");
    step(ST_FETCH, 1'b0, 1'b0, "reset_hold");
    reset = 1'b1;
  endtask

  task automatic fetch(input int waits);
    mem_ready = 1'b0;
    for (int i = 0; i < waits; i++) step(ST_FETCH, 1'b0, 1'b0, "fetch_wait");
    mem_ready = 1'b1;
    step(ST_FETCH, 1'b1, 1'b1, "fetch");
  endtask

  // Monitor: every cycle with a pending expectation is compared mid-cycle.
  always @(negedge clk) begin
    item_t e;
    snap_t a;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      a = {state_o, pc_en, ir_write, pc_source, iord, mem_read, mem_write,
           reg_write, reg_dest, memtoreg, alu_src_a, alu_src_b, alu_control,
           trap, retired};
      checks++;
      if (a !== e.v) begin
        errors++;
        $display("FAIL %s @%0t: got %h required %h", e.tag, $time, a, e.v);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] fn_tab [4];
    logic [2:0] al_tab [4];
    fn_tab = '{FN_SUB, FN_AND, FN_OR, FN_SLT};
    al_tab = '{ALU_SUB, ALU_AND, ALU_OR, ALU_SLT};
    reset = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    exec_aluc = ALU_ADD; exp_ret = 8'd0; exp_trap = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // R-type add
    opcode = OP_RTYPE; funct = FN_ADD; exec_aluc = ALU_ADD;
    fetch(0);
    step(ST_DECODE, 1'b0, 1'b0, "add_decode");
    step(ST_EXEC,   1'b0, 1'b0, "add_exec");
    step(ST_ALUWB,  1'b0, 1'b0, "add_aluwb");
    exp_ret++;

    // remaining R-type ops, zero held high to expose pc_en leakage
    zero = 1'b1;
    for (int k = 0; k < 4; k++) begin
      funct = fn_tab[k]; exec_aluc = al_tab[k];
      fetch(0);
      step(ST_DECODE, 1'b0, 1'b0, "rtype_decode");
      step(ST_EXEC,   1'b0, 1'b0, "rtype_exec");
      step(ST_ALUWB,  1'b0, 1'b0, "rtype_aluwb");
      exp_ret++;
    end
    zero = 1'b0;

    // lw with three stalls in MEMRD; mem_ready high in DECODE/MEMADR is ignored
    opcode = OP_LW;
    fetch(0);
    step(ST_DECODE, 1'b0, 1'b0, "lw_decode");
    step(ST_MEMADR, 1'b0, 1'b0, "lw_memadr");
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step(ST_MEMRD, 1'b0, 1'b0, "lw_memrd_wait");
    mem_ready = 1'b1;
    step(ST_MEMRD, 1'b0, 1'b0, "lw_memrd");
    step(ST_MEMWB, 1'b0, 1'b0, "lw_memwb");
    exp_ret++;

    // sw with fetch and write stalls
    opcode = OP_SW;
    fetch(2);
    step(ST_DECODE, 1'b0, 1'b0, "sw_decode");
    step(ST_MEMADR, 1'b0, 1'b0, "sw_memadr");
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) step(ST_MEMWR, 1'b0, 1'b0, "sw_memwr_wait");
    mem_ready = 1'b1;
    step(ST_MEMWR, 1'b0, 1'b0, "sw_memwr");
    exp_ret++;

    // addi
    opcode = OP_ADDI;
    fetch(0);
    step(ST_DECODE, 1'b0, 1'b0, "addi_decode");
    step(ST_ADDIEX, 1'b0, 1'b0, "addi_ex");
    step(ST_ADDIWB, 1'b0, 1'b0, "addi_wb");
    exp_ret++;

    // beq taken then not taken
    opcode = OP_BEQ; zero = 1'b1;
    fetch(0);
    step(ST_DECODE, 1'b0, 1'b0, "beq1_decode");
    step(ST_BRANCH, 1'b1, 1'b0, "beq_taken");
    exp_ret++;
    zero = 1'b0;
    fetch(0);
    step(ST_DECODE, 1'b0, 1'b0, "beq0_decode");
    step(ST_BRANCH, 1'b0, 1'b0, "beq_not_taken");
    exp_ret++;

    // illegal funct traps from EXEC
    opcode = OP_RTYPE; funct = 6'b111000; exec_aluc = 3'b000;
    fetch(0);
    step(ST_DECODE, 1'b0, 1'b0, "badfn_decode");
    step(ST_EXEC,   1'b0, 1'b0, "badfn_exec");
    exp_trap = 1'b1;
    for (int i = 0; i < 3; i++) step(ST_HALT, 1'b0, 1'b0, "badfn_halt");
    do_reset();

    // illegal opcode traps from DECODE and stays halted
    opcode = 6'b111111;
    fetch(0);
    step(ST_DECODE, 1'b0, 1'b0, "badop_decode");
    exp_trap = 1'b1;
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      step(ST_HALT, 1'b0, 1'b0, "badop_halt");
    end
    do_reset();

    // reset in the middle of a stalled store aborts it immediately
    opcode = OP_SW;
    fetch(0);
    step(ST_DECODE, 1'b0, 1'b0, "abort_decode");
    step(ST_MEMADR, 1'b0, 1'b0, "abort_memadr");
    mem_ready = 1'b0;
    step(ST_MEMWR, 1'b0, 1'b0, "abort_memwr");
    step(ST_MEMWR, 1'b0, 1'b0, "abort_memwr");
    do_reset();

    // store timeout: mem_write drops as HALT is entered
    opcode = OP_SW;
    fetch(0);
    step(ST_DECODE, 1'b0, 1'b0, "swto_decode");
    step(ST_MEMADR, 1'b0, 1'b0, "swto_memadr");
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) step(ST_MEMWR, 1'b0, 1'b0, "swto_memwr_wait");
    exp_trap = 1'b1;
    step(ST_HALT, 1'b0, 1'b0, "swto_halt");
    step(ST_HALT, 1'b0, 1'b0, "swto_halt");
    do_reset();

    // 256 jumps wrap the 8-bit retired counter back to 0
    opcode = OP_J;
    for (int n = 0; n < 256; n++) begin
      fetch(0);
      step(ST_DECODE, 1'b0, 1'b0, "j_decode");
      step(ST_JUMP,   1'b1, 1'b0, "j_jump");
      exp_ret++;
    end

    // fetch timeout after WAIT_MAX stalled cycles
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) step(ST_FETCH, 1'b0, 1'b0, "fetchto_wait");
    exp_trap = 1'b1;
    step(ST_HALT, 1'b0, 1'b0, "fetchto_halt");
    step(ST_HALT, 1'b0, 1'b0, "fetchto_halt");

    @(negedge clk); #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
